packet_bit_serializer: RTL and testbench
========================================

Name: packet_bit_serializer

Overview:
- Parametrised successor to the transmitter's packet flattening stage.
- Accepts a whole packet of PACKET_WIDTH words of WORD_BITS bits through a valid/ready handshake, then emits it as a timed serial bit stream for the BPSK modulator.
- Adds configurable word width, bit period and per-packet bit order, plus done/last flags and abort on reset.

Parameters:
- PACKET_WIDTH, 8, number of words per packet (>=1)
- WORD_BITS, 8, bits per word (>=1)
- BIT_PERIOD, 1, clock cycles each bit is held (>=1)
- IDLE_LEVEL, 0, value driven on bit_out when not transmitting
- PREAMBLE_BITS, 16, preamble length; used only with the optional feature
- PREAMBLE_PATTERN, 16'hAAAA, preamble value sent MSB first; used only with the optional feature

Ports:
- clk, input, 1, system clock; all logic on its rising edge
- reset, input, 1, synchronous active-high reset
- packet_in, input, PACKET_WIDTH*WORD_BITS, flattened packet; word i at [i*WORD_BITS +: WORD_BITS]
- packet_valid, input, 1, packet_in and msb_first are valid
- packet_ready, output, 1, block can accept a packet
- msb_first, input, 1, sampled at accept: 1 = send bit WORD_BITS-1 of each word first; 0 = send bit 0 first
- bit_out, output, 1, current serial bit
- bit_strobe, output, 1, high on the first cycle of each bit
- bit_last, output, 1, high for every cycle of the final payload bit
- busy, output, 1, transmission in progress
- done, output, 1, one-cycle pulse after the final bit completes

Behaviour:
- Reset (synchronous, active-high) from any state, including mid-packet:
  - Next state IDLE; the packet is discarded.
  - Reset values: packet_ready=1, bit_out=IDLE_LEVEL, bit_strobe=0, bit_last=0, busy=0, done=0.
  - All counters cleared.
- States: IDLE, (PREAMBLE), SHIFT.
- IDLE:
  - Outputs: packet_ready=1, busy=0, bit_out=IDLE_LEVEL.
  - Accept occurs on a rising edge where packet_valid and packet_ready are both 1.
  - On accept: register packet_in and msb_first, clear the word index, bit index and period counter, then go to SHIFT (or PREAMBLE).
- Not IDLE:
  - packet_ready=0 and busy=1.
  - packet_valid is ignored; no latch, no queuing.
- SHIFT, bit ordering:
  - Words are sent in index order 0..PACKET_WIDTH-1.
  - Within each word, bit order follows the registered msb_first.
- SHIFT, timing:
  - Each bit is held on bit_out for exactly BIT_PERIOD cycles.
  - bit_strobe=1 on the first of those cycles only.
  - The first payload bit appears the cycle after accept (latency 1).
  - Total SHIFT duration = PACKET_WIDTH*WORD_BITS*BIT_PERIOD cycles.
- Counter roll-over:
  - Period counter wraps from BIT_PERIOD-1 to 0, advancing the bit index.
  - Bit index wraps from WORD_BITS-1 to 0, advancing the word index.
  - If BIT_PERIOD=1, bit_strobe is high every SHIFT cycle.
- bit_last: high during all BIT_PERIOD cycles of bit (PACKET_WIDTH-1, final bit).
- End of last bit period:
  - Go to IDLE.
  - done=1 for exactly that first IDLE cycle, with packet_ready=1 in the same cycle.
  - A packet_valid present in the done cycle is accepted, so back-to-back packets have a gap of one IDLE cycle.
- Counter widths: $clog2 of each bound, minimum 1 bit. No arithmetic overflow is permitted.

Optional Feature:
- Macro: SERIALIZER_PREAMBLE_EN.
- Defined:
  - On accept, enter PREAMBLE instead of SHIFT.
  - Send PREAMBLE_BITS bits of PREAMBLE_PATTERN, MSB first, regardless of msb_first.
  - Same BIT_PERIOD timing and bit_strobe rules as SHIFT; bit_last stays 0.
  - Then enter SHIFT with no gap.
  - Total duration grows by PREAMBLE_BITS*BIT_PERIOD cycles.
- Undefined: PREAMBLE state and its counter are absent; PREAMBLE_* parameters are unused.

Test Plan:
- PACKET_WIDTH=2, WORD_BITS=8, BIT_PERIOD=1, word0=0xC1, word1=0x3A, msb_first=1 -> bit_out on 16 consecutive cycles = 1100_0001_0011_1010; bit_last on cycle 16; done cycle 17.
- Same packet, msb_first=0 -> bit_out = 1000_0011_0101_1100.
- BIT_PERIOD=4, same packet, msb_first=1 -> each bit held 4 cycles; bit_strobe on cycles 1,5,...,61; busy for 64 cycles; done on cycle 65.
- packet_valid held high during transmission with a changed packet_in -> stream unchanged; second packet accepted in the done cycle and starts the next cycle.
- reset asserted during bit 5 -> next cycle bit_out=IDLE_LEVEL, busy=0, packet_ready=1, done never pulses; a new packet after reset transmits correctly.
- SERIALIZER_PREAMBLE_EN, PREAMBLE_BITS=16, PREAMBLE_PATTERN=0xAAAA, BIT_PERIOD=1 -> 1010...10 for 16 cycles, then payload; done on cycle 33.

Source files
------------

// File: rtl/packet_bit_serializer.sv
// packet_bit_serializer: accepts a flattened packet of PACKET_WIDTH words over a
// valid/ready handshake and emits it as a timed serial bit stream, each bit held
// for BIT_PERIOD cycles. Bit order within each word is selected per packet.
// Optional preamble is enabled by defining SERIALIZER_PREAMBLE_EN.
module packet_bit_serializer #(
    parameter int                       PACKET_WIDTH     = 8,
    parameter int                       WORD_BITS        = 8,
    parameter int                       BIT_PERIOD       = 1,
    parameter logic                     IDLE_LEVEL       = 1'b0,
    parameter int                       PREAMBLE_BITS    = 16,
    parameter logic [PREAMBLE_BITS-1:0] PREAMBLE_PATTERN = 16'hAAAA
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [PACKET_WIDTH*WORD_BITS-1:0] packet_in,
    input  logic                            packet_valid,
    output logic                            packet_ready,
    input  logic                            msb_first,
    output logic                            bit_out,
    output logic                            bit_strobe,
    output logic                            bit_last,
    output logic                            busy,
    output logic                            done
);

    localparam int WORD_W   = (PACKET_WIDTH > 1) ? $clog2(PACKET_WIDTH) : 1;
    localparam int BIT_W    = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;
    localparam int PERIOD_W = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;

`ifdef SERIALIZER_PREAMBLE_EN
    localparam int PRE_W = (PREAMBLE_BITS > 1) ? $clog2(PREAMBLE_BITS) : 1;
    typedef enum logic [1:0] {S_IDLE, S_PREAMBLE, S_SHIFT} state_t;
`else
    typedef enum logic [0:0] {S_IDLE, S_SHIFT} state_t;
`endif

    state_t               state;
    state_t               state_next;
    logic [WORD_BITS-1:0] words [PACKET_WIDTH];
    logic                 msb_reg;
    logic [WORD_W-1:0]    word_idx;
    logic [BIT_W-1:0]     bit_idx;
    logic [PERIOD_W-1:0]  period_cnt;
    logic                 done_q;
    logic                 period_end;
    logic                 bit_end;
    logic                 word_end;
    logic [WORD_BITS-1:0] cur_word;
    logic [BIT_W-1:0]     bit_sel;

`ifdef SERIALIZER_PREAMBLE_EN
    logic [PRE_W-1:0]     pre_idx;
    logic                 pre_end;
    logic [PRE_W-1:0]     pre_sel;

    assign pre_end = (pre_idx == PRE_W'(PREAMBLE_BITS - 1));
    assign pre_sel = PRE_W'(PREAMBLE_BITS - 1) - pre_idx;
`endif

    assign period_end = (period_cnt == PERIOD_W'(BIT_PERIOD - 1));
    assign bit_end    = (bit_idx == BIT_W'(WORD_BITS - 1));
    assign word_end   = (word_idx == WORD_W'(PACKET_WIDTH - 1));
    assign cur_word   = words[word_idx];
    assign bit_sel    = msb_reg ? (BIT_W'(WORD_BITS - 1) - bit_idx) : bit_idx;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and output generation
    always_comb begin
        state_next   = state;
        packet_ready = 1'b0;
        busy         = 1'b1;
        bit_out      = IDLE_LEVEL;
        bit_strobe   = 1'b0;
        bit_last     = 1'b0;
        done         = done_q;
        case (state)
            S_IDLE: begin
                packet_ready = 1'b1;
                busy         = 1'b0;
                if (packet_valid) begin
`ifdef SERIALIZER_PREAMBLE_EN
                    state_next = S_PREAMBLE;
`else
                    state_next = S_SHIFT;
`endif
                end
            end
`ifdef SERIALIZER_PREAMBLE_EN
            S_PREAMBLE: begin
                bit_out    = PREAMBLE_PATTERN[pre_sel];
                bit_strobe = (period_cnt == '0);
                if (period_end && pre_end) begin
                    state_next = S_SHIFT;
                end
            end
`endif
            S_SHIFT: begin
                bit_out    = cur_word[bit_sel];
                bit_strobe = (period_cnt == '0);
                bit_last   = word_end && bit_end;
                if (period_end && bit_end && word_end) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Packet capture, bit/word/period counters and the done flag
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < PACKET_WIDTH; i++) begin
                words[i] <= '0;
            end
            msb_reg    <= 1'b0;
            word_idx   <= '0;
            bit_idx    <= '0;
            period_cnt <= '0;
            done_q     <= 1'b0;
`ifdef SERIALIZER_PREAMBLE_EN
            pre_idx    <= '0;
`endif
        end else begin
            done_q <= (state == S_SHIFT) && period_end && bit_end && word_end;
            case (state)
                S_IDLE: begin
                    if (packet_valid) begin
                        for (int unsigned i = 0; i < PACKET_WIDTH; i++) begin
                            words[i] <= packet_in[i*WORD_BITS +: WORD_BITS];
                        end
                        msb_reg    <= msb_first;
                        word_idx   <= '0;
                        bit_idx    <= '0;
                        period_cnt <= '0;
`ifdef SERIALIZER_PREAMBLE_EN
                        pre_idx    <= '0;
`endif
                    end
                end
`ifdef SERIALIZER_PREAMBLE_EN
                S_PREAMBLE: begin
                    period_cnt <= period_end ? '0 : period_cnt + 1'b1;
                    if (period_end) begin
                        pre_idx <= pre_end ? '0 : pre_idx + 1'b1;
                    end
                end
`endif
                S_SHIFT: begin
                    period_cnt <= period_end ? '0 : period_cnt + 1'b1;
                    if (period_end) begin
                        bit_idx <= bit_end ? '0 : bit_idx + 1'b1;
                        if (bit_end) begin
                            word_idx <= word_end ? '0 : word_idx + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_packet_bit_serializer.sv
// Directed testbench for packet_bit_serializer: two instances (BIT_PERIOD 1 and 4)
// with 2-word, 8-bit packets. Preamble expectations follow SERIALIZER_PREAMBLE_EN.
module tb_packet_bit_serializer;

    localparam logic [15:0] PRE      = 16'hAAAA;
    localparam logic [15:0] PKT_A    = {8'h3A, 8'hC1};
    localparam logic [15:0] PKT_B    = {8'h5F, 8'h96};
    localparam logic [15:0] A_MSB    = 16'b1100_0001_0011_1010;
    localparam logic [15:0] A_LSB    = 16'b1000_0011_0101_1100;
    localparam logic [15:0] B_LSB    = 16'b0110_1001_1111_1010;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] packet_in;
    logic        msb_first;
    logic        v1, v2;
    logic        ready1, out1, strobe1, last1, busy1, done1;
    logic        ready2, out2, strobe2, last2, busy2, done2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    packet_bit_serializer #(
        .PACKET_WIDTH(2), .WORD_BITS(8), .BIT_PERIOD(1), .IDLE_LEVEL(1'b0)
    ) dut1 (
        .clk(clk), .reset(reset), .packet_in(packet_in), .packet_valid(v1),
        .packet_ready(ready1), .msb_first(msb_first), .bit_out(out1),
        .bit_strobe(strobe1), .bit_last(last1), .busy(busy1), .done(done1)
    );

    packet_bit_serializer #(
        .PACKET_WIDTH(2), .WORD_BITS(8), .BIT_PERIOD(4), .IDLE_LEVEL(1'b0)
    ) dut2 (
        .clk(clk), .reset(reset), .packet_in(packet_in), .packet_valid(v2),
        .packet_ready(ready2), .msb_first(msb_first), .bit_out(out2),
        .bit_strobe(strobe2), .bit_last(last2), .busy(busy2), .done(done2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a packet to dut1, hold valid over one rising edge, then drop it.
    task automatic start1(input logic [15:0] pkt, input logic msb);
        @(negedge clk);
        packet_in = pkt;
        msb_first = msb;
        v1 = 1'b1;
        @(posedge clk);
        #1 v1 = 1'b0;
    endtask

    task automatic start2(input logic [15:0] pkt, input logic msb);
        @(negedge clk);
        packet_in = pkt;
        msb_first = msb;
        v2 = 1'b1;
        @(posedge clk);
        #1 v2 = 1'b0;
    endtask

    // Checks dut1 from the first cycle after accept through the done cycle.
    task automatic stream1(input logic [15:0] exp);
`ifdef SERIALIZER_PREAMBLE_EN
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("d1 pre bit", out1, PRE[15-i]);
            chk("d1 pre strobe", strobe1, 1'b1);
            chk("d1 pre last", last1, 1'b0);
            chk("d1 pre busy", busy1, 1'b1);
        end
`endif
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("d1 bit", out1, exp[15-i]);
            chk("d1 strobe", strobe1, 1'b1);
            chk("d1 last", last1, (i == 15) ? 1'b1 : 1'b0);
            chk("d1 busy", busy1, 1'b1);
            chk("d1 ready low", ready1, 1'b0);
            chk("d1 done low", done1, 1'b0);
        end
        @(negedge clk);
        chk("d1 done pulse", done1, 1'b1);
        chk("d1 done ready", ready1, 1'b1);
        chk("d1 done busy", busy1, 1'b0);
        chk("d1 done idle bit", out1, 1'b0);
        chk("d1 done last", last1, 1'b0);
    endtask

    task automatic stream2(input logic [15:0] exp);
`ifdef SERIALIZER_PREAMBLE_EN
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            chk("d2 pre bit", out2, PRE[15-(i/4)]);
            chk("d2 pre strobe", strobe2, (i % 4 == 0) ? 1'b1 : 1'b0);
            chk("d2 pre last", last2, 1'b0);
        end
`endif
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            chk("d2 bit", out2, exp[15-(i/4)]);
            chk("d2 strobe", strobe2, (i % 4 == 0) ? 1'b1 : 1'b0);
            chk("d2 last", last2, (i >= 60) ? 1'b1 : 1'b0);
            chk("d2 busy", busy2, 1'b1);
            chk("d2 done low", done2, 1'b0);
        end
        @(negedge clk);
        chk("d2 done pulse", done2, 1'b1);
        chk("d2 done ready", ready2, 1'b1);
        chk("d2 done busy", busy2, 1'b0);
        @(negedge clk);
        chk("d2 done one cycle", done2, 1'b0);
    endtask

    initial begin
        reset     = 1'b1;
        packet_in = '0;
        msb_first = 1'b0;
        v1        = 1'b0;
        v2        = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst ready", ready1, 1'b1);
        chk("rst busy", busy1, 1'b0);
        chk("rst done", done1, 1'b0);
        chk("rst bit", out1, 1'b0);
        chk("rst strobe", strobe1, 1'b0);
        chk("rst last", last1, 1'b0);
        chk("rst ready2", ready2, 1'b1);
        reset = 1'b0;

        // MSB-first packet, one cycle per bit
        start1(PKT_A, 1'b1);
        stream1(A_MSB);
        @(negedge clk);
        chk("d1 done one cycle", done1, 1'b0);

        // Same packet, LSB-first
        start1(PKT_A, 1'b0);
        stream1(A_LSB);

        // Four cycles per bit
        start2(PKT_A, 1'b1);
        stream2(A_MSB);

        // valid held high with new data during transmission; second packet
        // is taken in the done cycle and starts on the next one
        @(negedge clk);
        packet_in = PKT_A;
        msb_first = 1'b1;
        v1 = 1'b1;
        @(posedge clk);
        #1 packet_in = PKT_B;
        msb_first = 1'b0;
        stream1(A_MSB);
        @(posedge clk);
        #1 v1 = 1'b0;
        stream1(B_LSB);

        // Reset during the fifth bit aborts the packet
        start1(PKT_A, 1'b1);
`ifdef SERIALIZER_PREAMBLE_EN
        repeat (16) @(negedge clk);
`endif
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            chk("abort pre bit", out1, A_MSB[16-c]);
        end
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("abort bit idle", out1, 1'b0);
        chk("abort busy", busy1, 1'b0);
        chk("abort ready", ready1, 1'b1);
        chk("abort strobe", strobe1, 1'b0);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("abort no done", done1, 1'b0);
        end
        start1(PKT_A, 1'b0);
        stream1(A_LSB);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard time limit so the run always terminates
    initial begin
        #200000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
